// File: rtl/lcd_bus_responder_if.sv
// ----------------------------------------------------------------------------
// lcd_bus_responder_if
//   Character-LCD bus as seen by a passive listener, plus a debug view of the
//   listener's FSM state.
//
//   Signals:
//     lcd_en     enable strobe (write data is latched on its falling edge)
//     lcd_rs     0 = command, 1 = data
//     lcd_rw     0 = write, 1 = read
//     lcd_data   8-bit data bus
//     state_dbg  responder FSM state: 0 = IDLE, 1 = CLEAR
//
//   Modports:
//     master  drives the LCD bus (the LCD controller or a bench driver)
//     slave   observes the LCD bus and reports its FSM state (the responder)
// ----------------------------------------------------------------------------
interface lcd_bus_responder_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       state_dbg;

  modport master (
    output lcd_en,
    output lcd_rs,
    output lcd_rw,
    output lcd_data,
    input  state_dbg
  );

  modport slave (
    input  lcd_en,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_data,
    output state_dbg
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// ----------------------------------------------------------------------------
// lcd_bus_responder
//   Passive HD44780-style listener on the character-LCD bus. It decodes every
//   write strobe into commands / character writes and keeps a 32-entry shadow
//   of the visible 16x2 display, readable through a registered RAM port.
//   The bus is never driven.
//
//   Ports:
//     clk       system clock
//     rst       asynchronous, active-high reset
//     bus       LCD bus (slave modport; inputs only, plus state_dbg out)
//     raddr     shadow read address: 0-15 line 1, 16-31 line 2
//     rdata     shadow[raddr], one cycle later
//     busy      clear sequence in progress
//     ev_valid  one-cycle pulse per accepted write strobe
//     ev_rs     rs of the accepted strobe (valid with ev_valid)
//     ev_data   data byte of the accepted strobe (valid with ev_valid)
//     cursor    current DDRAM address
//     overrun   sticky: a write strobe arrived while busy
//
//   Bus semantics: the LCD bus has no valid/ready. A write transfer is a
//   falling edge of synchronized lcd_en with lcd_rw = 0; rs and data are
//   sampled from the same synchronizer stage as en. The responder cannot
//   stall the bus, so a transfer seen while busy is dropped and flagged.
// ----------------------------------------------------------------------------
module lcd_bus_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_bus_responder_if.slave    bus,
  input  logic [4:0]            raddr,
  output logic [7:0]            rdata,
  output logic                  busy,
  output logic                  ev_valid,
  output logic                  ev_rs,
  output logic [7:0]            ev_data,
  output logic [6:0]            cursor,
  output logic                  overrun
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer: {en, rs, rw, data[7:0]} travel together.
  // ---------------------------------------------------------------------------
  logic [10:0] sync_q [SYNC_STAGES];
  logic [10:0] bus_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bus_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Falling-edge detect. stb_q and the captured fields are registered so the
  // decode below sees a stable, single-cycle strobe.
  // ---------------------------------------------------------------------------
  logic       en_prev;
  logic       stb_q;
  logic       rs_q;
  logic       rw_q;
  logic [7:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev <= 1'b0;
      stb_q   <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      en_prev <= bus_s[10];
      stb_q   <= en_prev & ~bus_s[10];
      rs_q    <= bus_s[9];
      rw_q    <= bus_s[8];
      data_q  <= bus_s[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  state_t     state, state_n;
  logic [4:0] clr_idx, clr_idx_n;

  logic       accept;
  logic       drop;
  logic       clear_cmd;

  assign accept    = stb_q & ~rw_q & (state == ST_IDLE);
  assign drop      = stb_q & ~rw_q & (state == ST_CLEAR);
  assign clear_cmd = accept & ~rs_q & (data_q == 8'h01);

  // Reset lands in CLEAR so the shadow is initialised without a separate path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    case (state)
      ST_IDLE: begin
        if (clear_cmd) begin
          state_n   = ST_CLEAR;
          clr_idx_n = '0;
        end
      end
      ST_CLEAR: begin
        clr_idx_n = clr_idx + 5'd1;
        if (clr_idx == 5'd31) state_n = ST_IDLE;
      end
      default: begin
        state_n   = ST_IDLE;
        clr_idx_n = '0;
      end
    endcase
  end

  // Shadow write port: clear fill in CLEAR, character writes in IDLE.
  // Only DDRAM 0x00-0x0F and 0x40-0x4F are visible; others store nothing.
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;

  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = CLEAR_CHAR;
      end
      ST_IDLE: begin
        if (accept && rs_q) begin
          mem_wdata = data_q;
          if (cursor[6:4] == 3'b000) begin
            mem_we    = 1'b1;
            mem_waddr = {1'b0, cursor[3:0]};
          end else if (cursor[6:4] == 3'b100) begin
            mem_we    = 1'b1;
            mem_waddr = {1'b1, cursor[3:0]};
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.state_dbg = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Cursor stepping: the two 40-character lines are chained 0x27->0x40 and
  // 0x67->0x00; addresses above 0x67 just wrap modulo 128.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] step_cursor(input logic [6:0] c, input logic up);
    logic [6:0] r;
    if (up) begin
      if (c == 7'h27)      r = 7'h40;
      else if (c == 7'h67) r = 7'h00;
      else                 r = c + 7'd1;
    end else begin
      if (c == 7'h00)      r = 7'h67;
      else if (c == 7'h40) r = 7'h27;
      else                 r = c - 7'd1;
    end
    return r;
  endfunction

  logic inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor   <= '0;
      inc      <= 1'b1;
      ev_valid <= 1'b0;
      ev_rs    <= 1'b0;
      ev_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      ev_valid <= accept;
      if (accept) begin
        ev_rs   <= rs_q;
        ev_data <= data_q;
      end
      if (drop) overrun <= 1'b1;
      if (accept) begin
        if (rs_q) begin
          cursor <= step_cursor(cursor, inc);
        end else if (data_q[7]) begin
          cursor <= data_q[6:0];
        end else if (data_q[7:1] == 7'b0000001) begin
          cursor <= '0;
        end else if (data_q[7:2] == 6'b000001) begin
          inc <= data_q[1];
        end else if (data_q == 8'h01) begin
          cursor <= '0;
          inc    <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow RAM. Read-before-write: a same-cycle read returns the old value.
  // ---------------------------------------------------------------------------
  logic [7:0] shadow [32];

  always_ff @(posedge clk) begin
    if (mem_we) shadow[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= shadow[raddr];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_lcd_bus_responder
//   Drives LCD write/read strobes into lcd_bus_responder and compares every
//   cycle against a behavioural model of the display (cursor, entry mode,
//   visible shadow, clear timing, overrun), plus literal expectations.
// ----------------------------------------------------------------------------
module tb_lcd_bus_responder;
  localparam int SYNC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_responder_if bus ();
  logic [4:0] raddr;
  logic [7:0] rdata;
  logic       busy, ev_valid, ev_rs, overrun;
  logic [7:0] ev_data;
  logic [6:0] cursor;

  lcd_bus_responder #(.SYNC_STAGES(SYNC), .CLEAR_CHAR(8'h20)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .raddr    (raddr),
    .rdata    (rdata),
    .busy     (busy),
    .ev_valid (ev_valid),
    .ev_rs    (ev_rs),
    .ev_data  (ev_data),
    .cursor   (cursor),
    .overrun  (overrun)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. A strobe whose en falls on the driver edge k is due to
  // take effect at edge k + SYNC + 2.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         due;
    bit         rs;
    bit         rw;
    logic [7:0] d;
  } pend_t;

  pend_t      pend_q[$];
  int         cyc = 0;
  logic [7:0] m_shadow [32];
  logic [6:0] m_cursor;
  bit         m_inc;
  bit         m_overrun;
  int         m_clr_left;
  bit         exp_ev;
  bit         exp_rs;
  logic [7:0] exp_d;

  function automatic logic [6:0] m_step(input logic [6:0] c, input bit up);
    int v;
    v = c;
    if (up) v = (v == 'h27) ? 'h40 : (v == 'h67) ? 0 : (v + 1) % 128;
    else    v = (v == 0) ? 'h67 : (v == 'h40) ? 'h27 : (v + 127) % 128;
    return v[6:0];
  endfunction

  task automatic m_start_clear();
    m_clr_left = 32;
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
  endtask

  task automatic m_reset();
    pend_q.delete();
    m_cursor  = '0;
    m_inc     = 1'b1;
    m_overrun = 1'b0;
    exp_ev    = 1'b0;
    exp_rs    = 1'b0;
    exp_d     = '0;
    m_start_clear();
  endtask

  task automatic m_apply(input pend_t p, input bit was_busy);
    if (p.rw) return;
    if (was_busy) begin
      m_overrun = 1'b1;
      return;
    end
    exp_ev = 1'b1;
    exp_rs = p.rs;
    exp_d  = p.d;
    if (p.rs) begin
      if (m_cursor <= 7'h0F)                          m_shadow[m_cursor] = p.d;
      else if (m_cursor >= 7'h40 && m_cursor <= 7'h4F) m_shadow[16 + m_cursor - 64] = p.d;
      m_cursor = m_step(m_cursor, m_inc);
    end else if (p.d >= 8'h80) begin
      m_cursor = p.d[6:0];
    end else if (p.d == 8'h02 || p.d == 8'h03) begin
      m_cursor = '0;
    end else if (p.d >= 8'h04 && p.d <= 8'h07) begin
      m_inc = p.d[1];
    end else if (p.d == 8'h01) begin
      m_cursor = '0;
      m_inc    = 1'b1;
      m_start_clear();
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        bit was_busy;
        cyc++;
        exp_ev   = 1'b0;
        was_busy = (m_clr_left > 0);
        if (m_clr_left > 0) m_clr_left--;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) m_apply(pend_q.pop_front(), was_busy);
      end
    end
  end

  // per-cycle compare against the model, away from the active edge
  int ev_count = 0;
  int ev_rs1_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy", busy, m_clr_left > 0);
        check("cursor", cursor, m_cursor);
        check("overrun", overrun, m_overrun);
        check("ev_valid", ev_valid, exp_ev);
        if (exp_ev) begin
          check("ev_rs", ev_rs, exp_rs);
          check("ev_data", ev_data, exp_d);
        end
        if (ev_valid) begin
          ev_count++;
          if (ev_rs) ev_rs1_count++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic strobe(input bit rs, input bit rw, input logic [7:0] d);
    int hi, lo;
    hi = $urandom_range(5, 3);
    lo = $urandom_range(6, 3);
    @(posedge clk); #2;
    bus.lcd_rs   = rs;
    bus.lcd_rw   = rw;
    bus.lcd_data = d;
    bus.lcd_en   = 1'b1;
    repeat (hi) @(posedge clk);
    #2;
    bus.lcd_en = 1'b0;
    pend_q.push_back('{due: cyc + SYNC + 2, rs: rs, rw: rw, d: d});
    repeat (lo) @(posedge clk);
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((pend_q.size() != 0 || m_clr_left != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic read_expect(input string name, input logic [4:0] a, input logic [7:0] exp);
    @(posedge clk); #2;
    raddr = a;
    @(posedge clk);
    @(negedge clk);
    check(name, rdata, exp);
  endtask

  task automatic read_model(input logic [4:0] a);
    @(posedge clk); #2;
    raddr = a;
    @(posedge clk);
    @(negedge clk);
    check("rdata_model", rdata, m_shadow[a]);
  endtask

  task automatic busy_len(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 100);
    check(name, n, 32);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [6:0] hot_addr [10] = '{7'h00, 7'h0F, 7'h10, 7'h27, 7'h3F,
                                7'h40, 7'h4F, 7'h50, 7'h67, 7'h7F};

  initial begin
    int ev0, rs0;
    bus.lcd_en   = 1'b0;
    bus.lcd_rs   = 1'b0;
    bus.lcd_rw   = 1'b0;
    bus.lcd_data = '0;
    raddr        = '0;

    // reset state
    @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_cursor", cursor, 7'h00);
    check("rst_overrun", overrun, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    busy_len("reset_busy_len");
    idle_wait();
    for (int i = 0; i < 32; i++) read_expect("init_fill", i[4:0], 8'h20);

    // set address 0, entry mode increment, "HELLO"
    ev0 = ev_count;
    rs0 = ev_rs1_count;
    strobe(1'b0, 1'b0, 8'h80);
    strobe(1'b0, 1'b0, 8'h06);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, hello[i]);
    idle_wait();
    check("hello_ev_count", ev_count - ev0, 7);
    check("hello_ev_rs1", ev_rs1_count - rs0, 5);
    check("hello_cursor", cursor, 7'h05);
    check("model_cursor_hello", m_cursor, 7'h05);
    check("model_shadow0", m_shadow[0], 8'h48);
    for (int i = 0; i < 5; i++) read_expect("hello_rdata", i[4:0], hello[i]);

    // line 2, then the 0x27 -> 0x40 wrap with an invisible write
    strobe(1'b0, 1'b0, 8'hC0);
    strobe(1'b1, 1'b0, 8'h31);
    strobe(1'b1, 1'b0, 8'h32);
    strobe(1'b1, 1'b0, 8'h33);
    idle_wait();
    check("line2_cursor", cursor, 7'h43);
    strobe(1'b0, 1'b0, 8'hA7);
    strobe(1'b1, 1'b0, 8'h41);
    idle_wait();
    check("wrap27_cursor", cursor, 7'h40);
    strobe(1'b1, 1'b0, 8'h41);
    idle_wait();
    check("wrap27_cursor2", cursor, 7'h41);
    read_expect("line2_16", 5'd16, 8'h41);
    read_expect("line2_17", 5'd17, 8'h32);
    read_expect("line2_18", 5'd18, 8'h33);

    // decrement mode from 0 wraps to 0x67
    strobe(1'b0, 1'b0, 8'h04);
    strobe(1'b0, 1'b0, 8'h80);
    strobe(1'b1, 1'b0, 8'h5A);
    idle_wait();
    check("dec_wrap_cursor", cursor, 7'h67);
    read_expect("dec_shadow0", 5'd0, 8'h5A);

    // clear followed by a strobe while busy
    strobe(1'b0, 1'b0, 8'h01);
    strobe(1'b1, 1'b0, 8'h55);
    idle_wait();
    check("clear_overrun", overrun, 1'b1);
    check("clear_cursor", cursor, 7'h00);
    for (int i = 0; i < 32; i++) read_expect("clear_fill", i[4:0], 8'h20);

    // randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      int k;
      k = $urandom_range(99, 0);
      if (k < 45)      strobe(1'b1, 1'b0, 8'($urandom_range(126, 32)));
      else if (k < 60) strobe(1'b0, 1'b0, {1'b1, hot_addr[$urandom_range(9, 0)]});
      else if (k < 66) strobe(1'b0, 1'b0, {1'b1, 7'($urandom_range(127, 0))});
      else if (k < 75) strobe(1'b0, 1'b0, 8'($urandom_range(7, 4)));
      else if (k < 79) strobe(1'b0, 1'b0, 8'($urandom_range(3, 2)));
      else if (k < 85) strobe(1'b1, 1'b1, 8'($urandom_range(255, 0)));
      else if (k < 87) strobe(1'b0, 1'b0, 8'h01);
      else             strobe(1'b0, 1'b0, 8'($urandom_range(127, 8)));
    end
    idle_wait();
    for (int i = 0; i < 32; i++) read_model(i[4:0]);

    // reset 10 cycles into a clear
    strobe(1'b0, 1'b0, 8'h01);
    begin
      int n;
      n = 0;
      while (pend_q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
    end
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midclear_rst_busy", busy, 1'b1);
    check("midclear_rst_cursor", cursor, 7'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    busy_len("midclear_busy_len");
    #3;
    check("midclear_cursor", cursor, 7'h00);
    check("midclear_overrun", overrun, 1'b0);
    idle_wait();

    // read strobe produces no event
    ev0 = ev_count;
    strobe(1'b1, 1'b1, 8'h77);
    strobe(1'b0, 1'b1, 8'h80);
    idle_wait();
    check("rw_no_event", ev_count - ev0, 0);
    check("rw_cursor", cursor, 7'h00);
    read_expect("rw_no_store", 5'd0, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
